// File: rtl/vu_pkg.sv
// Shared VU-meter constants: default sample width, bar size and the derived step.
package vu_pkg;

    localparam int VU_DATA_W     = 16;
    localparam int VU_NLEDS      = 8;
    localparam int VU_LOG2_NLEDS = $clog2(VU_NLEDS);
    localparam int VU_STEP       = (1 << (VU_DATA_W - 1)) / VU_NLEDS;

    // STEP is a power of two, so each bar threshold is i shifted left by this amount.
    function automatic int vu_step_shift(input int data_w, input int nleds);
        return data_w - 1 - $clog2(nleds);
    endfunction

endpackage

// File: rtl/vu_thermo.sv
// Combinational thermometer encoder: level -> lit count n and bar pattern.
module vu_thermo
    import vu_pkg::*;
#(
    parameter int DATA_W = VU_DATA_W,
    parameter int NLEDS  = VU_NLEDS
) (
    input  logic [DATA_W-2:0]        level,
    output logic [NLEDS-1:0]         bar,
    output logic [$clog2(NLEDS):0]   n
);

    localparam int L2      = $clog2(NLEDS);
    localparam int STEP_SH = vu_step_shift(DATA_W, NLEDS);

    // Thresholds rise monotonically, so the last index exceeded gives the count.
    always_comb begin
        bar = '0;
        n   = '0;
        for (int i = 0; i < NLEDS; i++) begin
            if (level > ((DATA_W-1)'(i) << STEP_SH)) begin
                bar[i] = 1'b1;
                n      = (L2+1)'(i + 1);
            end
        end
    end

endmodule

// File: rtl/vu_level_tracker.sv
// VU level tracker: instant attack, proportional decay on tick, held peak marker.
module vu_level_tracker
    import vu_pkg::*;
#(
    parameter int DATA_W      = VU_DATA_W,
    parameter int NLEDS       = VU_NLEDS,
    parameter int DECAY_SHIFT = 3,
    parameter int HOLD_TICKS  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic              tick,
    output logic [NLEDS-1:0]  led,
    output logic [NLEDS-1:0]  peak_led
);

    localparam int PW = $clog2(NLEDS) + 1;
    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    logic [DATA_W-2:0] level_q, level_d;
    logic [DATA_W-2:0] mag, decayed, dec_amt;
    logic [DATA_W-1:0] neg_sample;
    logic [PW-1:0]     peak_idx_q, peak_idx_d, n_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [NLEDS-1:0]  bar_d, bar_q;
    logic [NLEDS-1:0]  led_q, peak_led_q, peak_led_d;

    // Most negative sample has no positive twin, so it clamps to full scale.
    always_comb begin
        neg_sample = '0 - sample;
        mag        = sample[DATA_W-2:0];
        if (sample[DATA_W-1]) begin
            if (sample[DATA_W-2:0] == '0) mag = '1;
            else                          mag = neg_sample[DATA_W-2:0];
        end
    end

    always_comb begin
        dec_amt = level_q >> DECAY_SHIFT;
        if (dec_amt == '0) dec_amt = (DATA_W-1)'(1);
        decayed = level_q;
        if (tick && level_q != '0) decayed = level_q - dec_amt;
        level_d = decayed;
        if (sample_valid && mag > decayed) level_d = mag;
    end

    vu_thermo #(
        .DATA_W (DATA_W),
        .NLEDS  (NLEDS)
    ) u_thermo (
        .level  (level_d),
        .bar    (bar_d),
        .n      (n_d)
    );

    always_comb begin
        peak_idx_d = peak_idx_q;
        hold_cnt_d = hold_cnt_q;
        if (n_d >= peak_idx_q) begin
            peak_idx_d = n_d;
            hold_cnt_d = HW'(HOLD_TICKS);
        end else if (tick) begin
            if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - HW'(1);
            else                  peak_idx_d = peak_idx_q - PW'(1);
        end
    end

    always_comb begin
        peak_led_d = '0;
        for (int i = 0; i < NLEDS; i++) begin
            if (peak_idx_q == PW'(i + 1)) peak_led_d[i] = 1'b1;
        end
    end

    // The bar is staged once so led lags the level update by exactly one cycle, like peak_led.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q    <= '0;
            peak_idx_q <= '0;
            hold_cnt_q <= '0;
            bar_q      <= '0;
            led_q      <= '0;
            peak_led_q <= '0;
        end else begin
            level_q    <= level_d;
            peak_idx_q <= peak_idx_d;
            hold_cnt_q <= hold_cnt_d;
            bar_q      <= bar_d;
            led_q      <= bar_q;
            peak_led_q <= peak_led_d;
        end
    end

    assign led      = led_q;
    assign peak_led = peak_led_q;

endmodule
